weight_rom_arbiter: RTL

//  Shares one weight/bias ROM (valid/ready addr + data channels) among N_REQ requesters.

---
 rtl/weight_rom_arbiter_if.sv | 35 +++
 rtl/weight_rom_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/weight_rom_arbiter_if.sv
// Bus bundle for weight_rom_arbiter: requester-side and ROM-side valid/ready channels.
// slave  : the arbiter's view of the bundle.
// master : the environment's view (requesters plus ROM wrapper).
interface weight_rom_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
);
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    req_addr_valid;
  logic [N_REQ-1:0]    req_addr_ready;
  logic [DW-1:0]       req_data;
  logic [N_REQ-1:0]    req_data_valid;
  logic [N_REQ-1:0]    req_data_ready;
  logic [AW-1:0]       rom_addr;
  logic                rom_addr_valid;
  logic                rom_addr_ready;
  logic [DW-1:0]       rom_data;
  logic                rom_data_valid;
  logic                rom_data_ready;

  modport slave (
    input  req_addr, req_addr_valid, req_data_ready,
    input  rom_addr_ready, rom_data, rom_data_valid,
    output req_addr_ready, req_data, req_data_valid,
    output rom_addr, rom_addr_valid, rom_data_ready
  );

  modport master (
    output req_addr, req_addr_valid, req_data_ready,
    output rom_addr_ready, rom_data, rom_data_valid,
    input  req_addr_ready, req_data, req_data_valid,
    input  rom_addr, rom_addr_valid, rom_data_ready
  );
endinterface

// File: rtl/weight_rom_arbiter.sv
// weight_rom_arbiter: round-robin sharing of one weight/bias ROM among N_REQ
// requesters, one addr->data transaction in flight at a time.
// Optional feature macro: ARB_STATS_EN adds per-requester saturating grant
// counters on the grant_count port.
module weight_rom_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  weight_rom_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   grant_count
`endif
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick;
  logic          pick_found;
  int unsigned   pick_idx;
  logic [DW-1:0] data_q;
  logic          resp_done;

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      pick_idx = (32'(last_grant) + i) % N_REQ;
      if (!pick_found && bus.req_addr_valid[pick_idx]) begin
        pick_found = 1'b1;
        pick       = GW'(pick_idx);
      end
    end
  end

  assign resp_done = (state == S_RESP) && bus.req_data_ready[grant];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (pick_found) state_nx = S_ADDR;
      S_ADDR: begin
        if (bus.rom_addr_ready)              state_nx = S_DATA;
        else if (!bus.req_addr_valid[grant]) state_nx = S_IDLE;
      end
      S_DATA: if (bus.rom_data_valid) state_nx = S_RESP;
      S_RESP: if (resp_done)          state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs: each channel is driven only in its own state, zero elsewhere.
  always_comb begin
    bus.req_addr_ready = '0;
    bus.req_data_valid = '0;
    bus.rom_addr       = '0;
    bus.rom_addr_valid = 1'b0;
    bus.rom_data_ready = 1'b0;
    unique case (state)
      S_ADDR: begin
        bus.rom_addr_valid        = 1'b1;
        bus.rom_addr              = bus.req_addr[grant*AW +: AW];
        bus.req_addr_ready[grant] = bus.rom_addr_ready;
      end
      S_DATA: bus.rom_data_ready       = 1'b1;
      S_RESP: bus.req_data_valid[grant] = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_data = data_q;

  // Grant, round-robin pointer and captured ROM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= GW'(N_REQ - 1);
      data_q     <= '0;
    end else begin
      if (state == S_IDLE && pick_found)         grant      <= pick;
      if (state == S_DATA && bus.rom_data_valid) data_q     <= bus.rom_data;
      if (resp_done)                             last_grant <= grant;
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ*16-1:0] grant_cnt;

  // Per-requester completed-transaction counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (resp_done) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant == GW'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign grant_count = grant_cnt;
`endif

endmodule
